// File: rtl/noc_traffic_monitor.sv
// ==========================================================================
// noc_traffic_monitor : sink-side NoC monitor (packet count, run cycles,
// latency sum/max, destination check).                      Revision 1.0
// ==========================================================================
`default_nettype none

module noc_traffic_monitor #(
  parameter int NUM_PE     = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_PE),
  parameter int PKT_LIMIT  = 100,
  parameter int TS_WIDTH   = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_start,
  input  logic                                    i_clear,
  input  logic [NUM_PE*(ADDR_WIDTH+DATA_WIDTH)-1:0] i_pkt_data,
  input  logic [NUM_PE-1:0]                       i_pkt_valid,
  output logic [NUM_PE-1:0]                       o_pkt_ready,
  output logic [TS_WIDTH-1:0]                     o_timestamp,
  output logic [CNT_WIDTH-1:0]                    o_total_pkts,
  output logic [CNT_WIDTH-1:0]                    o_cycles,
  output logic [CNT_WIDTH+TS_WIDTH-1:0]           o_lat_sum,
  output logic [TS_WIDTH-1:0]                     o_lat_max,
  output logic [CNT_WIDTH-1:0]                    o_addr_err_cnt,
  output logic                                    o_running,
  output logic                                    o_done
);

  localparam int PKT_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int LSUM_W = CNT_WIDTH + TS_WIDTH;
  localparam logic [CNT_WIDTH-1:0] TOTAL_LIMIT = CNT_WIDTH'(NUM_PE * PKT_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_PE-1:0]      ready_q, ready_d;
  logic [TS_WIDTH-1:0]    ts_q;
  logic [CNT_WIDTH-1:0]   total_q, total_d;
  logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
  logic [LSUM_W-1:0]      lsum_q, lsum_d;
  logic [TS_WIDTH-1:0]    lmax_q, lmax_d;
  logic [CNT_WIDTH-1:0]   err_q, err_d;

  logic [NUM_PE-1:0]      acc;
  logic [NUM_PE-1:0]      addr_bad;
  logic [TS_WIDTH-1:0]    lat_w [NUM_PE];
  logic [CNT_WIDTH-1:0]   acc_cnt;
  logic [CNT_WIDTH-1:0]   err_inc;
  logic [LSUM_W-1:0]      lat_inc;
  logic [TS_WIDTH-1:0]    lat_peak;
  logic [CNT_WIDTH-1:0]   total_upd;
  logic                   clear_stats;
  logic                   run_upd;
  logic                   unused_pkt_bits;

  // Payload bits above the timestamp are not inspected by the monitor.
  assign unused_pkt_bits = ^i_pkt_data;

  // ready_q is high exactly while in RUN, so it also gates acceptance.
  assign acc = i_pkt_valid & ready_q;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_chan
    assign lat_w[k]    = ts_q - i_pkt_data[k*PKT_W +: TS_WIDTH];
    assign addr_bad[k] = i_pkt_data[k*PKT_W+DATA_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(k);
  end

  always_comb begin
    acc_cnt  = '0;
    err_inc  = '0;
    lat_inc  = '0;
    lat_peak = lmax_q;
    for (int k = 0; k < NUM_PE; k++) begin
      if (acc[k]) begin
        acc_cnt = acc_cnt + CNT_WIDTH'(1);
        lat_inc = lat_inc + LSUM_W'(lat_w[k]);
        if (addr_bad[k]) err_inc = err_inc + CNT_WIDTH'(1);
        if (lat_w[k] > lat_peak) lat_peak = lat_w[k];
      end
    end
  end

  assign total_upd = total_q + acc_cnt;

  always_comb begin
    state_d     = state_q;
    clear_stats = 1'b0;
    run_upd     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (i_start) begin
        state_d     = ST_RUN;
        clear_stats = 1'b1;
      end
      ST_RUN: begin
        run_upd = 1'b1;
        // Overshoot in the final cycle is kept: every accepted packet counts.
        if (total_upd >= TOTAL_LIMIT) state_d = ST_DONE;
      end
      ST_DONE: if (i_clear) begin
        state_d     = ST_IDLE;
        clear_stats = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    total_d  = total_q;
    cycles_d = cycles_q;
    lsum_d   = lsum_q;
    lmax_d   = lmax_q;
    err_d    = err_q;
    if (clear_stats) begin
      total_d  = '0;
      cycles_d = '0;
      lsum_d   = '0;
      lmax_d   = '0;
      err_d    = '0;
    end else if (run_upd) begin
      total_d  = total_upd;
      cycles_d = cycles_q + CNT_WIDTH'(1);
      lsum_d   = lsum_q + lat_inc;
      lmax_d   = lat_peak;
      err_d    = err_q + err_inc;
    end
  end

  assign ready_d = {NUM_PE{state_d == ST_RUN}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= '0;
      ts_q     <= '0;
      total_q  <= '0;
      cycles_q <= '0;
      lsum_q   <= '0;
      lmax_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      ts_q     <= ts_q + TS_WIDTH'(1);
      total_q  <= total_d;
      cycles_q <= cycles_d;
      lsum_q   <= lsum_d;
      lmax_q   <= lmax_d;
      err_q    <= err_d;
    end
  end

  assign o_pkt_ready    = ready_q;
  assign o_timestamp    = ts_q;
  assign o_total_pkts   = total_q;
  assign o_cycles       = cycles_q;
  assign o_lat_sum      = lsum_q;
  assign o_lat_max      = lmax_q;
  assign o_addr_err_cnt = err_q;
  assign o_running      = (state_q == ST_RUN);
  assign o_done         = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: doc/noc_traffic_monitor.md
Name: noc_traffic_monitor

Overview:
- Synthesizable sink-side traffic monitor for the tree NoC, parametrised in PE count, data width and packet budget.
- Sits on the router-to-PE output ports (one channel per PE). It accepts delivered packets and counts them, measures run duration and latency, and checks each packet's destination address.
- Lets throughput and latency be measured on hardware, where only simulation could do it before.
- Generators stamp injection time from this block's free-running timestamp.

Parameters:
NUM_PE, 8, number of monitored channels (>=2)
DATA_WIDTH, 32, payload width per packet
ADDR_WIDTH, $clog2(NUM_PE), destination address field width
PKT_LIMIT, 100, packets per PE; run completes at NUM_PE*PKT_LIMIT total
TS_WIDTH, 16, timestamp width (<= DATA_WIDTH)
CNT_WIDTH, 32, width of packet, cycle and error counters

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  pulse; begin measurement run
i_clear  in  1  pulse; return from DONE to IDLE and zero statistics
i_pkt_data  in  NUM_PE*(ADDR_WIDTH+DATA_WIDTH)  channel k at slice k; each packet is {addr, data}, with data[TS_WIDTH-1:0] = injection timestamp
i_pkt_valid  in  NUM_PE  per-channel valid
o_pkt_ready  out  NUM_PE  per-channel ready
o_timestamp  out  TS_WIDTH  free-running cycle counter for generators
o_total_pkts  out  CNT_WIDTH  packets accepted this run
o_cycles  out  CNT_WIDTH  cycles spent in RUN
o_lat_sum  out  CNT_WIDTH+TS_WIDTH  sum of packet latencies
o_lat_max  out  TS_WIDTH  maximum packet latency
o_addr_err_cnt  out  CNT_WIDTH  packets whose addr != channel index
o_running  out  1  state==RUN
o_done  out  1  state==DONE

Behaviour:
- Reset:
  - All counters and statistics are 0. State is IDLE. o_pkt_ready is all 0.
  - o_timestamp is 0.
  - Asserting rst_n low mid-run aborts immediately, with no partial results retained.
- o_timestamp increments every cycle out of reset, independent of state, and wraps modulo 2^TS_WIDTH.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on i_start. Statistics are zeroed on that edge.
  - RUN -> DONE on the edge where the updated o_total_pkts >= NUM_PE*PKT_LIMIT.
  - DONE -> IDLE on i_clear. i_clear also zeroes statistics.
  - i_start is ignored outside IDLE. i_clear is ignored outside DONE.
- o_pkt_ready is all 1 in RUN (registered from next state, so it is high in the first RUN cycle) and all 0 otherwise. A packet is accepted when valid&ready on channel k.
- Per cycle in RUN, every accepted channel updates the statistics in parallel:
  - o_total_pkts += popcount(accepted). This may overshoot the limit when several channels fire in the final cycle; all accepted packets are counted.
  - latency_k = (o_timestamp - ts_k) mod 2^TS_WIDTH. o_lat_sum += sum of latency_k over accepted channels.
  - o_lat_max = max(o_lat_max, all accepted latency_k).
  - o_addr_err_cnt += count of accepted k with addr_k != k.
- o_cycles increments on every RUN cycle, including the cycle that triggers DONE.
- All statistics update with 1-cycle latency after acceptance.
- All statistics hold in DONE until i_clear.
- Counters wrap at 2^CNT_WIDTH; no saturation.
- Packets presented while not in RUN are not accepted and not counted.

Test Plan:
1. Reset held, then released -> all outputs 0 and o_pkt_ready=0; o_timestamp reads 5 after 5 cycles.
2. NUM_PE=8, PKT_LIMIT=2, i_start, then all 8 channels valid with correct addr for 2 consecutive cycles -> o_total_pkts=16, o_done=1 on the next edge, o_cycles=2, o_pkt_ready=0.
3. Channel 3 sends a packet with ts = o_timestamp-7 (including wrap case: ts=0xFFFE, now=0x0005) -> latency 7; o_lat_sum=7, o_lat_max=7.
4. Channel 5 sends addr=2, other channels send correct addr -> o_addr_err_cnt=1 while o_total_pkts counts every packet.
5. Final cycle with 3 simultaneous packets when 1 remains to the limit (limit 16, total 15) -> o_total_pkts=18 and DONE; further valids are not accepted; i_clear -> IDLE with zeroed statistics.
6. rst_n low mid-RUN, then i_start before i_clear -> asynchronous return to IDLE with stats 0; i_start in DONE is ignored.
